// File: rtl/ivl_uvm_ovl_req_ack_gen_if.sv
// Handshake bundle between the req/ack stimulus generator and its driver/observer.
// The generator sits on the slave side; the bench or control logic uses the master side.
interface ivl_uvm_ovl_req_ack_gen_if #(
   parameter int CNT_W = 16
);
   logic             start;
   logic [3:0]       ack_dly;
   logic [1:0]       err_mode;
   logic             req;
   logic             ack;
   logic             busy;
   logic             done;
   logic             timeout;
   logic [CNT_W-1:0] txn_cnt;

   modport master (
      output start, ack_dly, err_mode,
      input  req, ack, busy, done, timeout, txn_cnt
   );

   modport slave (
      input  start, ack_dly, err_mode,
      output req, ack, busy, done, timeout, txn_cnt
   );
endinterface

// File: rtl/ivl_uvm_ovl_req_ack_gen.sv
// Req/ack traffic source: requester FSM drives req, responder FSM drives ack, with programmable ack delay and error modes.
// Mode 0: ack rises T+1+ack_dly, done T+4+ack_dly; start is dropped while busy, nothing is queued.
module ivl_uvm_ovl_req_ack_gen #(
   parameter int MAX_ACK_CYCLE = 3,
   parameter int CNT_W         = 16
) (
   input logic                      clk,
   input logic                      rst_n,
   ivl_uvm_ovl_req_ack_gen_if.slave hs
);

   localparam int WC_W = $clog2(MAX_ACK_CYCLE + 2);
   localparam logic [WC_W-1:0] MAX_W = WC_W'(MAX_ACK_CYCLE);

   localparam logic [1:0] R_IDLE      = 2'd0;
   localparam logic [1:0] R_REQ       = 2'd1;
   localparam logic [1:0] R_WAIT_DROP = 2'd2;

   localparam logic [1:0] A_IDLE = 2'd0;
   localparam logic [1:0] A_DLY  = 2'd1;
   localparam logic [1:0] A_ACK  = 2'd2;

   localparam logic [1:0] M_LEGAL = 2'd0;
   localparam logic [1:0] M_SPUR  = 2'd1;
   localparam logic [1:0] M_DROP  = 2'd2;
   localparam logic [1:0] M_NOACK = 2'd3;

   logic [1:0]       r_state_q, r_state_d;
   logic [1:0]       a_state_q, a_state_d;
   logic             req_q, req_d;
   logic             ack_q, ack_d;
   logic             done_q, done_d;
   logic             timeout_q, timeout_d;
   logic [CNT_W-1:0] txn_cnt_q, txn_cnt_d;
   logic [1:0]       mode_q, mode_d;
   logic [WC_W-1:0]  wait_cnt_q, wait_cnt_d;
   logic [3:0]       dly_cnt_q, dly_cnt_d;
   logic             spur_start;

   always_comb begin
      r_state_d  = r_state_q;
      req_d      = req_q;
      done_d     = 1'b0;
      timeout_d  = 1'b0;
      txn_cnt_d  = txn_cnt_q;
      mode_d     = mode_q;
      wait_cnt_d = wait_cnt_q;
      spur_start = 1'b0;
      case (r_state_q)
         R_IDLE: begin
            if (hs.start) begin
               mode_d = hs.err_mode;
               if (hs.err_mode == M_SPUR) begin
                  spur_start = 1'b1;
               end else begin
                  req_d      = 1'b1;
                  r_state_d  = R_REQ;
                  wait_cnt_d = '0;
               end
            end
         end
         R_REQ: begin
            if (mode_q == M_DROP) begin
               req_d     = 1'b0;
               r_state_d = R_IDLE;
            end else if (ack_q) begin
               req_d     = 1'b0;
               r_state_d = R_WAIT_DROP;
            end else if (wait_cnt_q < MAX_W) begin
               wait_cnt_d = wait_cnt_q + WC_W'(1);
            end else if (wait_cnt_q == MAX_W) begin
               // Counter moves past MAX so the timeout pulse fires only once per txn.
               timeout_d  = 1'b1;
               wait_cnt_d = wait_cnt_q + WC_W'(1);
               if (mode_q == M_NOACK) begin
                  req_d     = 1'b0;
                  r_state_d = R_IDLE;
               end
            end
         end
         R_WAIT_DROP: begin
            if (!ack_q) begin
               done_d    = 1'b1;
               txn_cnt_d = txn_cnt_q + CNT_W'(1);
               r_state_d = R_IDLE;
            end
         end
         default: begin
            req_d     = 1'b0;
            r_state_d = R_IDLE;
         end
      endcase
   end

   always_comb begin
      a_state_d = a_state_q;
      ack_d     = ack_q;
      dly_cnt_d = dly_cnt_q;
      case (a_state_q)
         A_IDLE: begin
            if (spur_start) begin
               // Spurious ack reuses A_ACK: req is already 0, so it drops next edge.
               ack_d     = 1'b1;
               a_state_d = A_ACK;
            end else if (req_q && mode_q != M_NOACK) begin
               if (hs.ack_dly == 4'd0) begin
                  ack_d     = 1'b1;
                  a_state_d = A_ACK;
               end else begin
                  dly_cnt_d = hs.ack_dly;
                  a_state_d = A_DLY;
               end
            end
         end
         A_DLY: begin
            if (!req_q) begin
               dly_cnt_d = 4'd0;
               a_state_d = A_IDLE;
            end else if (dly_cnt_q <= 4'd1) begin
               dly_cnt_d = 4'd0;
               ack_d     = 1'b1;
               a_state_d = A_ACK;
            end else begin
               dly_cnt_d = dly_cnt_q - 4'd1;
            end
         end
         A_ACK: begin
            if (!req_q) begin
               ack_d     = 1'b0;
               a_state_d = A_IDLE;
            end
         end
         default: begin
            ack_d     = 1'b0;
            a_state_d = A_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state_q  <= R_IDLE;
         a_state_q  <= A_IDLE;
         req_q      <= 1'b0;
         ack_q      <= 1'b0;
         done_q     <= 1'b0;
         timeout_q  <= 1'b0;
         txn_cnt_q  <= '0;
         mode_q     <= M_LEGAL;
         wait_cnt_q <= '0;
         dly_cnt_q  <= 4'd0;
      end else begin
         r_state_q  <= r_state_d;
         a_state_q  <= a_state_d;
         req_q      <= req_d;
         ack_q      <= ack_d;
         done_q     <= done_d;
         timeout_q  <= timeout_d;
         txn_cnt_q  <= txn_cnt_d;
         mode_q     <= mode_d;
         wait_cnt_q <= wait_cnt_d;
         dly_cnt_q  <= dly_cnt_d;
      end
   end

   assign hs.req     = req_q;
   assign hs.ack     = ack_q;
   assign hs.busy    = (r_state_q != R_IDLE);
   assign hs.done    = done_q;
   assign hs.timeout = timeout_q;
   assign hs.txn_cnt = txn_cnt_q;

   // Structural invariants of the two FSMs.
   a_done_timeout_excl: assert property (@(posedge clk) disable iff (!rst_n)
      !(done_q && timeout_q));
   a_idle_no_req: assert property (@(posedge clk) disable iff (!rst_n)
      (r_state_q == R_IDLE) |-> !req_q);
   a_ack_state: assert property (@(posedge clk) disable iff (!rst_n)
      ack_q == (a_state_q == A_ACK));

endmodule

// File: tb/tb_ivl_uvm_ovl_req_ack_gen.sv
// Scoreboard bench for ivl_uvm_ovl_req_ack_gen: stimulus pushes expected req/ack/timeout/done events,
// a negedge monitor pops and compares them against what the generator produces.
module tb_ivl_uvm_ovl_req_ack_gen;

   localparam int CNT_W = 3;
   localparam int MAXC  = 3;

   localparam int EV_REQ_RISE = 0;
   localparam int EV_REQ_FALL = 1;
   localparam int EV_ACK_RISE = 2;
   localparam int EV_ACK_FALL = 3;
   localparam int EV_TIMEOUT  = 4;
   localparam int EV_DONE     = 5;

   typedef struct {
      int kind;
      int cyc;
      int val;
   } ev_t;

   logic clk = 1'b0;
   logic rst_n;

   always #5 clk = ~clk;

   ivl_uvm_ovl_req_ack_gen_if #(.CNT_W(CNT_W)) hs ();

   ivl_uvm_ovl_req_ack_gen #(
      .MAX_ACK_CYCLE(MAXC),
      .CNT_W        (CNT_W)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .hs   (hs)
   );

   ev_t  exp_q[$];
   int   n_tests = 0;
   int   n_fail  = 0;
   int   cyc     = 0;
   int   exp_cnt = 0;
   bit   mon_en  = 1'b0;
   logic req_p   = 1'b0;
   logic ack_p   = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic report(input int act, input int exp, input string name);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // Keeps the queue ordered by cycle, then by the order the monitor reports kinds.
   task automatic push_exp(input int kind, input int c, input int val);
      ev_t e;
      int  i;
      e.kind = kind;
      e.cyc  = c;
      e.val  = val;
      i = 0;
      while (i < exp_q.size() &&
             (exp_q[i].cyc < c || (exp_q[i].cyc == c && exp_q[i].kind <= kind)))
         i++;
      exp_q.insert(i, e);
   endtask

   task automatic see(input int kind, input int val);
      ev_t e;
      n_tests++;
      if (exp_q.size() == 0) begin
         n_fail++;
         $display("FAIL unexpected_event: got kind=%0d cyc=%0d val=%0d, expected no event", kind, cyc, val);
      end else begin
         e = exp_q.pop_front();
         if (e.kind != kind || e.cyc != cyc || e.val != val) begin
            n_fail++;
            $display("FAIL event: got kind=%0d cyc=%0d val=%0d, expected kind=%0d cyc=%0d val=%0d",
                     kind, cyc, val, e.kind, e.cyc, e.val);
         end
      end
   endtask

   always @(negedge clk) begin
      if (mon_en) begin
         if (hs.req && !req_p) see(EV_REQ_RISE, int'(hs.busy));
         if (!hs.req && req_p) see(EV_REQ_FALL, int'(hs.busy));
         if (hs.ack && !ack_p) see(EV_ACK_RISE, int'(hs.busy));
         if (!hs.ack && ack_p) see(EV_ACK_FALL, int'(hs.busy));
         if (hs.timeout)       see(EV_TIMEOUT, int'(hs.busy));
         if (hs.done)          see(EV_DONE, int'(hs.txn_cnt));
      end
      req_p = hs.req;
      ack_p = hs.ack;
   end

   // Reference timing relative to edge T where start is accepted.
   task automatic expect_txn(input int mode, input int d, input int t);
      case (mode)
         0: begin
            push_exp(EV_REQ_RISE, t, 1);
            push_exp(EV_ACK_RISE, t + 1 + d, 1);
            if (d >= MAXC) push_exp(EV_TIMEOUT, t + 1 + MAXC, 1);
            push_exp(EV_REQ_FALL, t + 2 + d, 1);
            push_exp(EV_ACK_FALL, t + 3 + d, 1);
            exp_cnt = (exp_cnt + 1) % (1 << CNT_W);
            push_exp(EV_DONE, t + 4 + d, exp_cnt);
         end
         1: begin
            push_exp(EV_ACK_RISE, t, 0);
            push_exp(EV_ACK_FALL, t + 1, 0);
         end
         2: begin
            push_exp(EV_REQ_RISE, t, 1);
            push_exp(EV_REQ_FALL, t + 1, 0);
         end
         default: begin
            push_exp(EV_REQ_RISE, t, 1);
            push_exp(EV_REQ_FALL, t + 1 + MAXC, 0);
            push_exp(EV_TIMEOUT, t + 1 + MAXC, 0);
         end
      endcase
   endtask

   task automatic issue(input int mode, input int d, output int t);
      hs.err_mode = 2'(mode);
      hs.ack_dly  = 4'(d);
      hs.start    = 1'b1;
      @(posedge clk);
      #1;
      t = cyc;
      hs.start = 1'b0;
   endtask

   task automatic wait_until(input int c);
      while (cyc < c) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic drain(input string name);
      for (int i = 0; i < 60; i++) begin
         if (exp_q.size() == 0) break;
         @(posedge clk);
         #1;
      end
      report(exp_q.size(), 0, {"drain_", name});
      repeat (3) begin
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int t;
      int ds_b2b[3]  = '{1, 0, 2};
      int ds_wrap[6] = '{0, 2, 3, 0, 1, 0};

      rst_n       = 1'b0;
      hs.start    = 1'b0;
      hs.ack_dly  = 4'd0;
      hs.err_mode = 2'd0;

      // Reset held with start toggling: everything stays quiet.
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         #1;
         hs.start = (i % 2 == 0);
         @(negedge clk);
         report(int'(hs.req), 0, "rst_req");
         report(int'(hs.ack), 0, "rst_ack");
         report(int'(hs.busy), 0, "rst_busy");
         report(int'(hs.txn_cnt), 0, "rst_txn_cnt");
         report(int'(hs.done | hs.timeout), 0, "rst_done_timeout");
      end
      hs.start = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      mon_en = 1'b1;

      issue(0, 1, t); expect_txn(0, 1, t); drain("mode0_d1");
      issue(0, 5, t); expect_txn(0, 5, t); drain("mode0_d5_timeout");
      issue(1, 0, t); expect_txn(1, 0, t); drain("mode1_spurious");
      issue(2, 2, t); expect_txn(2, 2, t); drain("mode2_drop");
      issue(3, 4, t); expect_txn(3, 4, t); drain("mode3_noack");

      // Async reset while the responder is counting down.
      mon_en = 1'b0;
      issue(0, 8, t);
      wait_until(t + 3);
      #2;
      rst_n = 1'b0;
      #1;
      report(int'(hs.req), 0, "midrst_req");
      report(int'(hs.ack), 0, "midrst_ack");
      report(int'(hs.busy), 0, "midrst_busy");
      report(int'(hs.txn_cnt), 0, "midrst_txn_cnt");
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      exp_q.delete();
      exp_cnt = 0;
      @(posedge clk);
      #1;
      mon_en = 1'b1;

      // Back-to-back txns; a start while busy and a start on the done edge are both dropped.
      for (int k = 0; k < 3; k++) begin
         issue(0, ds_b2b[k], t);
         expect_txn(0, ds_b2b[k], t);
         wait_until(t + 1);
         hs.err_mode = 2'd1;
         hs.start    = 1'b1;
         @(posedge clk);
         #1;
         hs.start    = 1'b0;
         hs.err_mode = 2'd0;
         wait_until(t + 3 + ds_b2b[k]);
         hs.start = 1'b1;
         @(posedge clk);
         #1;
         hs.start = 1'b0;
      end
      drain("back_to_back");
      report(int'(hs.txn_cnt), 3, "b2b_txn_cnt");

      // Counter runs 4..7 then wraps to 0 and 1; d=2/d=3 straddle the timeout bound.
      for (int k = 0; k < 6; k++) begin
         issue(0, ds_wrap[k], t);
         expect_txn(0, ds_wrap[k], t);
         drain("wrap");
      end
      report(int'(hs.txn_cnt), 1, "wrap_txn_cnt");
      report(exp_q.size(), 0, "queue_empty");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
